instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch-stage controller between the program counter register and decode. It reads the current PC, issues a read to instruction memory over a req/ack handshake, and holds the returned word in an instruction register (IR) with a valid/ready handshake to decode. It drives the PC register's next-value input and its write enable, for both sequential advance and branch redirect. Wait states and flushes are handled here, so the PC register stays a plain enabled register.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
INSTR_W, 16, instruction word width

Ports:
clk  in  1  single system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_in  in  ADDR_W  current PC register value
next_pc  out  ADDR_W  value for PC register input
pc_we  out  1  PC register write enable (combinational, one cycle per update)
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  read address, registered (req_addr)
imem_ack  in  1  read data valid; may coincide with first req cycle
imem_rdata  in  INSTR_W  read data, valid when imem_ack=1
ir_out  out  INSTR_W  instruction register
fetch_pc  out  ADDR_W  address ir_out was fetched from
ir_valid  out  1  IR holds an instruction for decode
ir_ready  in  1  decode accepts IR this cycle
branch_taken  in  1  redirect request from execute, single-cycle
branch_target  in  ADDR_W  redirect address

Behaviour:
- States: IDLE, FETCH, HOLD, DRAIN. Reset (rst=1 at an edge) forces IDLE, req_addr=0, ir_out=0, fetch_pc=0. While rst=1: imem_req=0, ir_valid=0, pc_we=0, next_pc=0.
- Reset mid-fetch abandons the outstanding request. Instruction memory is reset by the same rst.
- imem_req=1 exactly in FETCH and DRAIN. imem_addr=req_addr, held stable until ack. A request is never withdrawn except by reset.
- ir_valid = (state==HOLD) and not branch_taken. A transfer occurs on ir_valid and ir_ready.
- IDLE: req_addr<=pc_in; next state FETCH.
- FETCH, ack, no branch: ir_out<=imem_rdata, fetch_pc<=req_addr, pc_we=1, next_pc=req_addr+1 (mod 2^ADDR_W, 0xFF wraps to 0x00); go to HOLD.
- FETCH, no ack, no branch: stay in FETCH.
- HOLD, ir_ready, no branch: req_addr<=pc_in (already incremented); go to FETCH. Otherwise stay in HOLD with ir_out and fetch_pc stable.
- Branch (branch_taken=1, any non-reset state): pc_we=1, next_pc=branch_target this cycle. Branch overrides the sequential update when both occur. The IR is flushed and no decode transfer occurs.
  - From IDLE or HOLD: go to IDLE.
  - From FETCH: ack this cycle discards the data and goes to IDLE; without ack go to DRAIN.
  - From DRAIN: stay in DRAIN, or go to IDLE if ack. The latest target wins.
- DRAIN: hold req and req_addr until ack, discard rdata, then go to IDLE.
- imem_ack outside FETCH/DRAIN is ignored.
- pc_we=0 in all other cases, and next_pc=pc_in.
- Timing: zero-wait memory with ir_ready held high gives one instruction per 2 cycles. Each memory wait cycle adds one cycle. After a branch, the first request to the target issues 2 cycles later (via IDLE), or after the drain completes.

Test Plan:
1. Reset: rst=1 for 2 cycles, pc_in=0x37 -> imem_req=0, ir_valid=0, pc_we=0, ir_out=0. Cycle 2 after rst falls: imem_req=1, imem_addr=0x37.
2. Sequential fetch: bench PC register model, zero-wait memory returning {8'hA5, addr}, ir_ready=1 -> pc_we pulses every 2 cycles with next_pc 0x01, 0x02, 0x03. fetch_pc/ir_out pairs are (0x00, 0xA500), (0x01, 0xA501).
3. Wrap and wait states: PC=0xFF, ack 3 cycles after req -> imem_addr=0xFF stable for all 4 req cycles, then next_pc=0x00, pc_we=1 for one cycle. Next request goes to 0x00.
4. Decode stall: ir_ready=0 for 4 cycles in HOLD -> ir_valid=1, ir_out and fetch_pc unchanged, imem_req=0, pc_we=0. Then ir_ready=1 -> FETCH next cycle.
5. Branch during outstanding fetch: branch_taken with target 0x80 in FETCH, ack 2 cycles later with 0xDEAD -> pc_we=1, next_pc=0x80 in the branch cycle. 0xDEAD never appears with ir_valid=1. The next request is to address 0x80.
6. Branch coincident with ir_ready in HOLD: branch_taken=1, target 0x10 -> ir_valid=0 that cycle (no transfer), pc_we=1, next_pc=0x10. The following fetch goes to 0x10.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage controller: PC -> imem req/ack -> IR with valid/ready to decode.
// Owns PC sequencing and branch redirect so the PC register stays a plain enabled flop.
module instr_fetch_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               pc_we,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      fetch_pc_q <= '0;
      ir_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      ir_q       <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    ir_d       = ir_q;
    pc_we      = 1'b0;
    next_pc    = pc_in;
    // A redirect always wins over the sequential PC advance.
    if (branch_taken) begin
      pc_we   = 1'b1;
      next_pc = branch_target;
    end
    unique case (state_q)
      IDLE: begin
        if (!branch_taken) begin
          req_addr_d = pc_in;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          state_d = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          ir_d       = imem_rdata;
          fetch_pc_d = req_addr_q;
          pc_we      = 1'b1;
          next_pc    = req_addr_q + ADDR_W'(1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_d = IDLE;
        end else if (ir_ready) begin
          req_addr_d = pc_in;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pc_we   = 1'b0;
      next_pc = '0;
    end
  end

  assign imem_req  = !rst && (state_q == FETCH || state_q == DRAIN);
  assign ir_valid  = !rst && (state_q == HOLD) && !branch_taken;
  assign imem_addr = req_addr_q;
  assign ir_out    = ir_q;
  assign fetch_pc  = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table plus
// model-driven sequences for wait states, wrap and branch drain.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_in;
  logic [7:0]  next_pc;
  logic        pc_we;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir_out;
  logic [7:0]  fetch_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;

  instr_fetch_ctrl #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .next_pc       (next_pc),
    .pc_we         (pc_we),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir_out        (ir_out),
    .fetch_pc      (fetch_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  pc;
    logic        ack;
    logic [15:0] rd;
    logic        rdy;
    logic        br;
    logic [7:0]  tgt;
    logic        req;
    logic [7:0]  addr;
    logic        val;
    logic        we;
    logic [7:0]  npc;
    logic [15:0] ir;
    logic [7:0]  fpc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  pc_m;
  int          wait_n;
  int          wcnt;
  bit          use_ovr;
  logic [15:0] ovr;
  bit          dead_seen;

  function automatic vec_t v(
    input logic rs, input logic [7:0] pc, input logic ack,
    input logic [15:0] rd, input logic rdy, input logic br,
    input logic [7:0] tgt, input logic req, input logic [7:0] addr,
    input logic val, input logic we, input logic [7:0] npc,
    input logic [15:0] ir, input logic [7:0] fpc);
    vec_t r;
    r.rst = rs; r.pc = pc; r.ack = ack; r.rd = rd;
    r.rdy = rdy; r.br = br; r.tgt = tgt;
    r.req = req; r.addr = addr; r.val = val; r.we = we;
    r.npc = npc; r.ir = ir; r.fpc = fpc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rst_seq(input logic [7:0] pc0);
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    branch_taken = 1'b0;
    pc_m = pc0;
    wcnt = 0;
    @(posedge clk);
  endtask

  task automatic drive(input logic rdy, input logic br,
                       input logic [7:0] tgt);
    @(negedge clk);
    rst = 1'b0;
    pc_in = pc_m;
    ir_ready = rdy;
    branch_taken = br;
    branch_target = tgt;
    imem_ack = imem_req && (wcnt >= wait_n);
    imem_rdata = use_ovr ? ovr : {8'hA5, imem_addr};
    #1;
    if (ir_valid && ir_out == 16'hDEAD) dead_seen = 1'b1;
  endtask

  task automatic commit();
    if (pc_we) pc_m = next_pc;
    if (imem_req) wcnt = imem_ack ? 0 : wcnt + 1;
  endtask

  initial begin
    //          rst pc    ack rd        rdy br tgt   | req addr  val we npc   ir        fpc
    tbl[0]  = v(1, 8'h37, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00);
    tbl[1]  = v(1, 8'h37, 1, 16'h1111, 1, 1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 8'h00);
    tbl[2]  = v(0, 8'h37, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h37, 16'h0000, 8'h00);
    tbl[3]  = v(0, 8'h37, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h37, 0, 0, 8'h37, 16'h0000, 8'h00);
    tbl[4]  = v(0, 8'h37, 1, 16'h1234, 0, 0, 8'h00, 1, 8'h37, 0, 1, 8'h38, 16'h0000, 8'h00);
    tbl[5]  = v(0, 8'h38, 1, 16'hFFFF, 0, 0, 8'h00, 0, 8'h37, 1, 0, 8'h38, 16'h1234, 8'h37);
    tbl[6]  = v(0, 8'h38, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h37, 1, 0, 8'h38, 16'h1234, 8'h37);
    tbl[7]  = v(0, 8'h38, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h37, 1, 0, 8'h38, 16'h1234, 8'h37);
    tbl[8]  = v(0, 8'h38, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h37, 1, 0, 8'h38, 16'h1234, 8'h37);
    tbl[9]  = v(0, 8'h38, 0, 16'h0000, 1, 0, 8'h00, 0, 8'h37, 1, 0, 8'h38, 16'h1234, 8'h37);
    tbl[10] = v(0, 8'h38, 1, 16'h5678, 0, 0, 8'h00, 1, 8'h38, 0, 1, 8'h39, 16'h1234, 8'h37);
    tbl[11] = v(0, 8'h39, 0, 16'h0000, 1, 1, 8'h10, 0, 8'h38, 0, 1, 8'h10, 16'h5678, 8'h38);
    tbl[12] = v(0, 8'h10, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h38, 0, 0, 8'h10, 16'h5678, 8'h38);
    tbl[13] = v(0, 8'h10, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h10, 0, 0, 8'h10, 16'h5678, 8'h38);
    tbl[14] = v(0, 8'h10, 0, 16'h0000, 0, 1, 8'h20, 1, 8'h10, 0, 1, 8'h20, 16'h5678, 8'h38);
    tbl[15] = v(0, 8'h20, 0, 16'h0000, 0, 1, 8'h30, 1, 8'h10, 0, 1, 8'h30, 16'h5678, 8'h38);
    tbl[16] = v(0, 8'h30, 1, 16'hBEEF, 0, 0, 8'h00, 1, 8'h10, 0, 0, 8'h30, 16'h5678, 8'h38);
    tbl[17] = v(0, 8'h30, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h10, 0, 0, 8'h30, 16'h5678, 8'h38);
    tbl[18] = v(0, 8'h30, 1, 16'hBAD0, 0, 1, 8'h40, 1, 8'h30, 0, 1, 8'h40, 16'h5678, 8'h38);
    tbl[19] = v(0, 8'h40, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h30, 0, 0, 8'h40, 16'h5678, 8'h38);
    tbl[20] = v(0, 8'h40, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h40, 16'h5678, 8'h38);

    rst = 1'b1;
    pc_in = 8'h37;
    imem_ack = 1'b0;
    imem_rdata = '0;
    ir_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    wait_n = 0;
    wcnt = 0;
    use_ovr = 1'b0;
    ovr = '0;
    dead_seen = 1'b0;
    pc_m = '0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      pc_in = tbl[i].pc;
      imem_ack = tbl[i].ack;
      imem_rdata = tbl[i].rd;
      ir_ready = tbl[i].rdy;
      branch_taken = tbl[i].br;
      branch_target = tbl[i].tgt;
      #1;
      n_vec++;
      if (imem_req !== tbl[i].req || imem_addr !== tbl[i].addr ||
          ir_valid !== tbl[i].val || pc_we !== tbl[i].we ||
          next_pc !== tbl[i].npc || ir_out !== tbl[i].ir ||
          fetch_pc !== tbl[i].fpc) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b addr=%h val=%b we=%b npc=%h ir=%h fpc=%h expected req=%b addr=%h val=%b we=%b npc=%h ir=%h fpc=%h",
                 i, imem_req, imem_addr, ir_valid, pc_we, next_pc, ir_out,
                 fetch_pc, tbl[i].req, tbl[i].addr, tbl[i].val, tbl[i].we,
                 tbl[i].npc, tbl[i].ir, tbl[i].fpc);
      end
    end

    // Zero-wait sequential fetch from PC 0 with decode always ready.
    rst_seq(8'h00);
    wait_n = 0;
    use_ovr = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 8'h00);
      chk("seq_we", {31'd0, pc_we}, {31'd0, c % 2 == 1});
      if (c % 2 == 1) chk("seq_npc", {24'd0, next_pc}, (c + 1) / 2);
      if (c == 2 || c == 4) begin
        chk("seq_val", {31'd0, ir_valid}, 1);
        chk("seq_fpc", {24'd0, fetch_pc}, c / 2 - 1);
        chk("seq_ir", {16'd0, ir_out}, 32'hA500 + c / 2 - 1);
      end
      commit();
    end

    // Three wait states at 0xFF, then wrap to 0x00.
    rst_seq(8'hFF);
    wait_n = 3;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 8'h00);
      if (c >= 1 && c <= 4) begin
        chk("wrap_req", {31'd0, imem_req}, 1);
        chk("wrap_addr", {24'd0, imem_addr}, 32'hFF);
        chk("wrap_we", {31'd0, pc_we}, {31'd0, c == 4});
      end
      if (c == 4) chk("wrap_npc", {24'd0, next_pc}, 0);
      if (c == 5) chk("wrap_ir", {16'd0, ir_out}, 32'hA5FF);
      if (c == 6) begin
        chk("wrap_req2", {31'd0, imem_req}, 1);
        chk("wrap_addr2", {24'd0, imem_addr}, 0);
      end
      commit();
    end

    // Branch while a fetch is outstanding; stale data must be drained.
    rst_seq(8'h00);
    wait_n = 2;
    use_ovr = 1'b1;
    ovr = 16'hDEAD;
    dead_seen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) begin
        wait_n = 0;
        use_ovr = 1'b0;
      end
      drive(1'b1, c == 1, 8'h80);
      if (c == 1) begin
        chk("br_we", {31'd0, pc_we}, 1);
        chk("br_npc", {24'd0, next_pc}, 32'h80);
      end
      if (c == 2 || c == 3) begin
        chk("drain_req", {31'd0, imem_req}, 1);
        chk("drain_addr", {24'd0, imem_addr}, 0);
        chk("drain_we", {31'd0, pc_we}, 0);
      end
      if (c == 5) chk("br_addr", {24'd0, imem_addr}, 32'h80);
      if (c == 6) chk("br_ir", {15'd0, ir_valid, ir_out}, 32'h1A580);
      commit();
    end
    chk("br_dead", {31'd0, dead_seen}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
